// File: rtl/chorus_delay_ctrl.sv
// rtl/chorus_delay_ctrl.sv - chorus delay-line sequencer: circular buffer, triangle LFO, tap read, mix
// Optional LINEAR_INTERP_EN: two-tap linear interpolation; undefined gives nearest-tap only.
module chorus_delay_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int BASE_DELAY = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clk_enable,
   input  logic              sample_valid,
   input  logic [15:0]       In1,
   input  logic [15:0]       rate,
   input  logic [7:0]        depth,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       Out1,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun,
   output logic              ce_out
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RA, S_RB, S_WAIT, S_MIX} state_t;

   state_t            state, state_nx;
   logic              enb;
   logic [ADDR_W-1:0] wr_ptr, rd_a;
   logic [23:0]       phase, prod;
   logic [15:0]       tri_w, in_q, rate_q, tap_a, wet, out1_q;
   logic [7:0]        depth_q, off;
   logic [16:0]       sum;
   logic              out_valid_q, overrun_q;

   assign enb    = clk_enable;
   assign ce_out = clk_enable;

   // Phase stays fixed for the whole sequence, so taps use the pre-increment phase
   assign tri_w = phase[23] ? ~phase[22:7] : phase[22:7];
   assign prod  = 24'(tri_w) * 24'(depth_q);
   assign off   = 8'(prod >> 16);
   assign rd_a  = wr_ptr - ADDR_W'(BASE_DELAY) - ADDR_W'(off);

`ifdef LINEAR_INTERP_EN
   logic [ADDR_W-1:0] rd_b;
   logic [15:0]       tap_b;
   logic [7:0]        frac;
   logic [24:0]       acc;

   assign rd_b = rd_a - ADDR_W'(1);
   assign frac = 8'(prod >> 8);
   assign acc  = 25'(tap_a) * 25'(9'd256 - 9'(frac)) + 25'(tap_b) * 25'(frac);
   assign wet  = 16'(acc >> 8);
`else
   assign wet  = tap_a;
`endif

   assign sum = 17'(in_q) + 17'(wet);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else if (enb)
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (sample_valid) state_nx = S_WR;
         S_WR:   state_nx = S_RA;
`ifdef LINEAR_INTERP_EN
         S_RA:   state_nx = S_RB;
`else
         S_RA:   state_nx = S_WAIT;
`endif
         S_RB:   state_nx = S_WAIT;
         S_WAIT: state_nx = S_MIX;
         S_MIX:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // While stalled, each read state keeps presenting the address its capture still needs
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_WR: begin
            mem_we    = enb;
            mem_addr  = wr_ptr;
            mem_wdata = in_q;
         end
         S_RA:   mem_addr = rd_a;
`ifdef LINEAR_INTERP_EN
         S_RB:   mem_addr = enb ? rd_b : rd_a;
         S_WAIT: mem_addr = rd_b;
`else
         S_WAIT: mem_addr = rd_a;
`endif
         default: mem_addr = '0;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign Out1      = out1_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         phase       <= '0;
         in_q        <= '0;
         rate_q      <= '0;
         depth_q     <= '0;
         tap_a       <= '0;
         out1_q      <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (enb) begin
         out_valid_q <= (state == S_MIX);
         if (sample_valid && state == S_IDLE) begin
            in_q    <= In1;
            rate_q  <= rate;
            depth_q <= depth;
         end
         if (sample_valid && state != S_IDLE)
            overrun_q <= 1'b1;
`ifdef LINEAR_INTERP_EN
         if (state == S_RB)
            tap_a <= mem_rdata;
`else
         if (state == S_WAIT)
            tap_a <= mem_rdata;
`endif
         if (state == S_MIX) begin
            out1_q <= 16'(sum >> 1);
            wr_ptr <= wr_ptr + ADDR_W'(1);
            phase  <= phase + 24'(rate_q);
         end
      end
   end

`ifdef LINEAR_INTERP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tap_b <= '0;
      else if (enb && state == S_WAIT)
         tap_b <= mem_rdata;
   end
`endif

endmodule

// File: tb/tb_chorus_delay_ctrl.sv
// tb/tb_chorus_delay_ctrl.sv - scoreboard bench for chorus_delay_ctrl with a behavioural delay-line model
module tb_chorus_delay_ctrl;

   localparam int AW = 10;
   localparam int BD = 16;
   localparam int DEPTH_MASK = (1 << AW) - 1;
`ifdef LINEAR_INTERP_EN
   localparam int LAT    = 6;
   localparam bit INTERP = 1'b1;
   localparam int GOLD2  = 1084;
`else
   localparam int LAT    = 5;
   localparam bit INTERP = 1'b0;
   localparam int GOLD2  = 1088;
`endif

   logic          clk = 1'b0;
   logic          reset_n, clk_enable, sample_valid;
   logic [15:0]   In1, rate;
   logic [7:0]    depth;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata, mem_rdata;
   logic [15:0]   Out1;
   logic          out_valid, busy, overrun, ce_out;

   chorus_delay_ctrl #(.ADDR_W(AW), .BASE_DELAY(BD)) dut (
      .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .sample_valid(sample_valid),
      .In1(In1), .rate(rate), .depth(depth), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .Out1(Out1), .out_valid(out_valid),
      .busy(busy), .overrun(overrun), .ce_out(ce_out)
   );

   always #5 clk = ~clk;

   logic [15:0] ram [1 << AW];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int rcyc = 0;
   int ecyc = 0;
   always @(posedge clk) begin
      rcyc <= rcyc + 1;
      if (clk_enable) ecyc <= ecyc + 1;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: delay line as a plain array indexed by sample count
   logic [15:0] m_mem [1 << AW];
   int          m_wr;
   logic [23:0] m_phase;

   function automatic logic [15:0] model_step(input logic [15:0] x, input logic [15:0] rt,
                                              input logic [7:0] dp);
      logic [15:0] tw;
      int prod, off, frac, a, b, wet;
      m_mem[m_wr] = x;
      tw   = m_phase[23] ? ~m_phase[22:7] : m_phase[22:7];
      prod = int'(tw) * int'(dp);
      off  = (prod >> 16) & 255;
      frac = (prod >> 8) & 255;
      a    = (m_wr - BD - off) & DEPTH_MASK;
      b    = (a - 1) & DEPTH_MASK;
      if (INTERP)
         wet = (int'(m_mem[a]) * (256 - frac) + int'(m_mem[b]) * frac) >> 8;
      else
         wet = int'(m_mem[a]);
      m_wr    = (m_wr + 1) & DEPTH_MASK;
      m_phase = m_phase + 24'(rt);
      return 16'((int'(x) + wet) >> 1);
   endfunction

   task automatic model_reset();
      m_wr    = 0;
      m_phase = '0;
   endtask

   typedef struct {
      logic [15:0] val;
      int ecyc0;
      int rcyc0;
      int lat;
      int rlat;
      int gold;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (reset_n) begin
         if (!clk_enable) check("mem_we_while_stalled", int'(mem_we), 0);
         if (out_valid && clk_enable) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_out_valid: Out1=%0d with no sample pending", Out1);
            end else begin
               mon_e = exp_q.pop_front();
               check("out1", int'(Out1), int'(mon_e.val));
               check("latency", ecyc - mon_e.ecyc0, mon_e.lat);
               if (mon_e.rlat >= 0) check("raw_latency", rcyc - mon_e.rcyc0, mon_e.rlat);
               if (mon_e.gold >= 0) check("out1_golden", int'(Out1), mon_e.gold);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] rt, input logic [7:0] dp,
                       input int rlat, input int gold);
      exp_t e;
      clk_enable   = 1'b1;
      sample_valid = 1'b1;
      In1          = x;
      rate         = rt;
      depth        = dp;
      e.val   = model_step(x, rt, dp);
      e.ecyc0 = ecyc;
      e.rcyc0 = rcyc;
      e.lat   = LAT;
      e.rlat  = rlat;
      e.gold  = gold;
      exp_q.push_back(e);
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_en(input int n, input bit stall);
      int k = 0;
      while (k < n) begin
         clk_enable = (stall && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
         tick();
         if (clk_enable) k++;
      end
      clk_enable = 1'b1;
   endtask

   task automatic drain();
      int t = 0;
      clk_enable = 1'b1;
      while (exp_q.size() != 0 && t < 50) begin
         tick();
         t++;
      end
      tick();
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; clk_enable = 1'b1; sample_valid = 1'b0;
      In1 = '0; rate = '0; depth = '0;
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i]   = '0;
         m_mem[i] = '0;
      end
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out1", int'(Out1), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_mem_wdata", int'(mem_wdata), 0);
      check("ce_out", int'(ce_out), 1);
      tick();
      reset_n = 1'b1;
      tick();

      // Impulse through a fixed delay of BD samples
      for (int n = 0; n < 40; n++) begin
         send((n == 20) ? 16'h1000 : 16'h0000, 16'h0000, 8'h00, -1,
              (n == 20 || n == 36) ? 16'h0800 : 0);
         wait_en(LAT - 1, 1'b0);
      end
      drain();
      do_reset();

      // Ramp with a modulated tap; sample 101 has a known interpolated result
      for (int n = 0; n < 102; n++) begin
         send(16'(16 * n), 16'h8000, 8'h80, LAT, (n == 101) ? GOLD2 : -1);
         wait_en(LAT - 1, 1'b0);
      end
      drain();

      // Three-cycle stall starting in the third cycle after the strobe
      send(16'h4321, 16'h1234, 8'h5a, LAT + 3, -1);
      tick();
      tick();
      clk_enable = 1'b0;
      repeat (3) tick();
      clk_enable = 1'b1;
      wait_en(LAT - 3, 1'b0);
      drain();

      // Second strobe while busy is dropped and sets the sticky flag
      check("overrun_before", int'(overrun), 0);
      send(16'h1111, 16'h0100, 8'h40, LAT, -1);
      tick();
      sample_valid = 1'b1;
      In1 = 16'hffff;
      tick();
      sample_valid = 1'b0;
      check("overrun_set", int'(overrun), 1);
      wait_en(LAT - 3, 1'b0);
      drain();
      check("overrun_hold", int'(overrun), 1);

      for (int i = 0; i < 60; i++) begin
         send(16'($urandom()), 16'($urandom()), 8'($urandom()), -1, -1);
         wait_en(LAT - 1 + int'($urandom_range(0, 3)), 1'b1);
      end
      drain();
      check("overrun_sticky", int'(overrun), 1);

      // Reset in the third cycle after the strobe aborts the sample
      send(16'h2222, 16'h0040, 8'hff, -1, -1);
      tick();
      tick();
      reset_n = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      model_reset();
      #1;
      check("abort_busy_now", int'(busy), 0);
      @(negedge clk);
      check("abort_out1", int'(Out1), 0);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_overrun", int'(overrun), 0);
      check("abort_mem_we", int'(mem_we), 0);
      check("abort_mem_addr", int'(mem_addr), 0);
      check("abort_mem_wdata", int'(mem_wdata), 0);
      tick();
      reset_n = 1'b1;
      tick();
      send(16'h3333, 16'h0000, 8'h00, LAT, -1);
      check("post_rst_mem_we", int'(mem_we), 1);
      check("post_rst_mem_addr", int'(mem_addr), 0);
      check("post_rst_mem_wdata", int'(mem_wdata), 16'h3333);
      wait_en(LAT - 1, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
